// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative signed multiply/divide for the execute stage.
// MULT uses shift-add and DIV uses restoring division. Both work on operand
// magnitudes, one bit per edge for WIDTH edges, with the sign applied at the end.
// Optional build macro MULTDIV_EARLY_DIV0_EN: a divide by zero skips RUN and
// completes after a single edge.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               is_div_q, is_div_d;
    logic               neg_q, neg_d;
    logic               skip_q, skip_d;      // DONE was entered without RUN (early div0)
    logic [WIDTH-1:0]   mcand_q, mcand_d;    // multiplicand / divisor magnitude
    logic [2*WIDTH-1:0] acc_q, acc_d;        // product accumulator; low half = dividend/quotient
    logic [WIDTH-1:0]   rem_q, rem_d;        // partial remainder (always < divisor)
    logic [WIDTH-1:0]   result_q, result_d;
    logic               exc_q, exc_d;
    logic               rdy_q, rdy_d;

    logic [WIDTH-1:0]   a_mag, b_mag, addend, qmag;
    logic [WIDTH:0]     sum, r;
    logic [2*WIDTH-1:0] prod;
    logic               ge;

    // Magnitudes are unsigned, so 0x80000000 maps to 2^31 without overflow
    assign a_mag = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
    assign b_mag = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = (state_q == RUN) || (state_q == DONE && !skip_q) || rdy_q;

    // Next-state, datapath iteration and sign fixup
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_div_d = is_div_q;
        neg_d    = neg_q;
        skip_d   = skip_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
        addend   = '0;
        sum      = '0;
        r        = '0;
        ge       = 1'b0;
        qmag     = '0;
        prod     = '0;
        case (state_q)
            IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    is_div_d = !ctrl_MULT;  // MULT wins a tie
                    neg_d    = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                    cnt_d    = '0;
                    rem_d    = '0;
                    skip_d   = 1'b0;
                    state_d  = RUN;
                    if (ctrl_MULT) begin
                        mcand_d = a_mag;
                        acc_d   = {{WIDTH{1'b0}}, b_mag};
                    end else begin
                        mcand_d = b_mag;
                        acc_d   = {{WIDTH{1'b0}}, a_mag};
`ifdef MULTDIV_EARLY_DIV0_EN
                        if (data_operandB == '0) begin
                            state_d = DONE;
                            skip_d  = 1'b1;
                        end
`endif
                    end
                end
            end
            RUN: begin
                if (is_div_q) begin
                    // Bring in the next dividend bit MSB first; subtract if it fits
                    r  = {rem_q, acc_q[WIDTH-1]};
                    ge = (r >= {1'b0, mcand_q});
                    rem_d = ge ? WIDTH'(r - {1'b0, mcand_q}) : r[WIDTH-1:0];
                    acc_d[WIDTH-1:0] = {acc_q[WIDTH-2:0], ge};
                end else begin
                    // Add multiplicand when the current multiplier LSB is set, shift right
                    addend = acc_q[0] ? mcand_q : '0;
                    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, addend};
                    acc_d  = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH-1))
                    state_d = DONE;
            end
            DONE: begin
                rdy_d   = 1'b1;
                state_d = IDLE;
                if (is_div_q) begin
                    qmag = acc_q[WIDTH-1:0];
                    if (mcand_q == '0) begin
                        result_d = '0;
                        exc_d    = 1'b1;
                    end else if (neg_q && qmag != '0) begin
                        result_d = -qmag;
                        exc_d    = 1'b0;
                    end else begin
                        // A positive 2^31 quotient cannot be represented
                        result_d = qmag;
                        exc_d    = qmag[WIDTH-1];
                    end
                end else begin
                    prod     = neg_q ? -acc_q : acc_q;
                    result_d = prod[WIDTH-1:0];
                    exc_d    = !((&prod[2*WIDTH-1:WIDTH-1]) || !(|prod[2*WIDTH-1:WIDTH-1]));
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            skip_q   <= 1'b0;
            mcand_q  <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_div_q <= is_div_d;
            neg_q    <= neg_d;
            skip_q   <= skip_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
        end
    end
endmodule

// File: tb/tb_mult_div_unit.sv
// Testbench for mult_div_unit: directed table, reset-abort sequence, and
// randomized operations against a plain-arithmetic reference model.
module tb_mult_div_unit;
    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] prev_res;
    logic        prev_exc;

`ifdef MULTDIV_EARLY_DIV0_EN
    localparam int DIV0_LAT = 1;
`else
    localparam int DIV0_LAT = 33;
`endif

    // op: 0 = MULT, 1 = DIV, 2 = both requests high
    typedef struct {
        int          op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        exc;
        int          lat;
    } vec_t;

    vec_t tbl[11];

    mult_div_unit #(.WIDTH(32)) dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: signed arithmetic straight from the operation definitions
    function automatic void model(input int op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e);
        longint p;
        int     q;
        if (op != 1) begin
            p = longint'($signed(a)) * longint'($signed(b));
            r = p[31:0];
            e = (p != longint'($signed(p[31:0])));
        end else if (b == 32'd0) begin
            r = 32'd0;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            q = $signed(a) / $signed(b);
            r = q;
            e = 1'b0;
        end
    endfunction

    // Called at a negedge; returns at the negedge of the RDY cycle so that
    // consecutive calls start back to back.
    task automatic run_op(input string name, input int op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] er, input logic ee,
                          input int elat);
        int   lat;
        logic busy_ok, hold_ok;
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = (op != 1);
        ctrl_DIV      = (op != 0);
        @(posedge clock);
        @(negedge clock);
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
        lat = -1;
        busy_ok = 1'b1;
        hold_ok = 1'b1;
        for (int n = 0; n <= 80 && lat < 0; n++) begin
            if (n > 0) begin
                @(posedge clock);
                @(negedge clock);
            end
            if (data_resultRDY) lat = n;
            else if (data_result !== prev_res || data_exception !== prev_exc) hold_ok = 1'b0;
            if (busy !== ((elat == 1) ? (n == elat) : 1'b1)) busy_ok = 1'b0;
        end
        chk({name, " latency"}, 32'(lat), 32'(elat));
        chk({name, " result"}, data_result, er);
        chk({name, " exception"}, {31'd0, data_exception}, {31'd0, ee});
        chk({name, " busy"}, {31'd0, busy_ok}, 32'd1);
        chk({name, " hold"}, {31'd0, hold_ok}, 32'd1);
        prev_res = er;
        prev_exc = ee;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: pick = 32'($signed($urandom_range(0, 40)) - 20);
            1: pick = 32'd0;
            2: pick = 32'h8000_0000;
            3: pick = 32'hFFFF_FFFF;
            4: pick = 32'($urandom_range(0, 65535));
            default: pick = $urandom;
        endcase
    endfunction

    initial begin
        logic        saw_rdy;
        logic [31:0] ra, rb, rr;
        logic        re;
        int          rop;

        tbl[0]  = '{0, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFD6, 1'b0, 33};
        tbl[1]  = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, 33};
        tbl[2]  = '{0, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33};
        tbl[3]  = '{1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0, 33};
        tbl[4]  = '{1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        tbl[5]  = '{1, 32'd5,         32'd0,         32'd0,         1'b1, DIV0_LAT};
        tbl[6]  = '{2, 32'd3,         32'd4,         32'd12,        1'b0, 33};
        tbl[7]  = '{1, 32'h8000_0000, 32'd1,         32'h8000_0000, 1'b0, 33};
        tbl[8]  = '{1, 32'd3,         32'hFFFF_FFF9, 32'd0,         1'b0, 33};
        tbl[9]  = '{0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 33};
        tbl[10] = '{1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        1'b0, 33};

        reset = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV = 1'b0;
        data_operandA = '0;
        data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("reset result", data_result, 32'd0);
        chk("reset exception", {31'd0, data_exception}, 32'd0);
        chk("reset rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        prev_res = 32'd0;
        prev_exc = 1'b0;

        // Directed table, issued back to back
        foreach (tbl[i])
            run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
                   tbl[i].res, tbl[i].exc, tbl[i].lat);

        @(posedge clock);
        @(negedge clock);
        chk("idle rdy", {31'd0, data_resultRDY}, 32'd0);
        chk("idle busy", {31'd0, busy}, 32'd0);
        chk("idle hold", data_result, prev_res);

        // Divide aborted by reset; the stray MULT request must be ignored
        data_operandA = 32'd100;
        data_operandB = 32'd7;
        ctrl_DIV = 1'b1;
        @(posedge clock);
        @(negedge clock);
        ctrl_DIV = 1'b0;
        saw_rdy = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            ctrl_MULT = (c == 10);
            reset = (c == 20);
            @(posedge clock);
            @(negedge clock);
            if (data_resultRDY) saw_rdy = 1'b1;
        end
        ctrl_MULT = 1'b0;
        reset = 1'b0;
        chk("abort no rdy", {31'd0, saw_rdy}, 32'd0);
        chk("abort result", data_result, 32'd0);
        chk("abort exception", {31'd0, data_exception}, 32'd0);
        chk("abort busy", {31'd0, busy}, 32'd0);
        prev_res = 32'd0;
        prev_exc = 1'b0;
        run_op("post-reset mult", 0, 32'd3, 32'd4, 32'd12, 1'b0, 33);

        // Random operations against the reference model
        for (int k = 0; k < 24; k++) begin
            rop = $urandom_range(0, 2);
            ra = pick();
            rb = pick();
            model(rop, ra, rb, rr, re);
            run_op($sformatf("rand%0d op%0d %h,%h", k, rop, ra, rb), rop, ra, rb, rr, re,
                   (rop == 1 && rb == 32'd0) ? DIV0_LAT : 33);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
